// File: rtl/btn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// btn_ctrl_pkg : shared arbiter state encoding, id width helper, defaults
// Revision     : 1.0
// ============================================================================
package btn_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_e;

    localparam int DEFAULT_TICK_DIV  = 50000;
    localparam int DEFAULT_SHIFT_LEN = 8;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sampler.sv
`default_nettype none
// ============================================================================
// btn_sampler : per-button debounce shift register, debounced level, press edge
// Revision    : 1.0
// ============================================================================
module btn_sampler
    import btn_ctrl_pkg::*;
#(
    parameter int SHIFT_LEN = DEFAULT_SHIFT_LEN
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    logic [SHIFT_LEN-1:0] shift_q, shift_d;
    logic                 level_q, level_d;
    logic                 level_prev_q;
    logic                 armed_q, armed_d;

    // Presses only count once a settled release has been seen, so a button
    // held through reset cannot produce an event when its level first falls.
    always_comb begin
        shift_d = shift_q;
        level_d = level_q;
        armed_d = armed_q;
        if (tick_i) begin
            shift_d = {shift_q[SHIFT_LEN-2:0], btn_i};
            if (&shift_d) begin
                level_d = 1'b1;
                armed_d = 1'b1;
            end else if (~|shift_d) begin
                level_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_q      <= '1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            armed_q      <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            armed_q      <= armed_d;
        end
    end

    assign level_o = level_q;
    assign press_o = armed_q & level_prev_q & ~level_q;

endmodule
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// btn_event_arbiter : debounced button presses -> round-robin event stream
// Revision          : 1.0
// ============================================================================
module btn_event_arbiter
    import btn_ctrl_pkg::*;
#(
    parameter  int N_BTN     = 4,
    parameter  int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter  int SHIFT_LEN = DEFAULT_SHIFT_LEN,
    localparam int ID_W      = id_width(N_BTN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    input  logic             drop_clr,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] dropped
);

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    logic [31:0]      presc_q;
    logic             tick;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] dropped_q, dropped_d;
    logic [N_BTN-1:0] grant_clr;
    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  evt_id_q, evt_id_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]  pick;
    logic             pick_found;
    logic             accept;

    assign tick = (presc_q == TICK_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 32'd1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_sampler #(
            .SHIFT_LEN (SHIFT_LEN)
        ) u_sampler (
            .clock   (clock),
            .reset   (reset),
            .tick_i  (tick),
            .btn_i   (btn[i]),
            .level_o (btn_state[i]),
            .press_o (press[i])
        );
    end

    // Round-robin scan starting just after the most recent grant.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            scan_idx = ID_W'((int'(last_grant_q) + k) % N_BTN);
            if (!pick_found && pending_q[scan_idx]) begin
                pick       = scan_idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        accept       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    evt_id_d = pick;
                    state_d  = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    accept       = 1'b1;
                    last_grant_d = evt_id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A press coinciding with the grant clear re-arms the bit instead of dropping.
    always_comb begin
        grant_clr = accept ? (N_BTN'(1) << evt_id_q) : '0;
        pending_d = press | (pending_q & ~grant_clr);
        dropped_d = (dropped_q & ~{N_BTN{drop_clr}}) | (press & pending_q & ~grant_clr);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            evt_id_q     <= '0;
            last_grant_q <= ID_W'(N_BTN - 1);
            pending_q    <= '0;
            dropped_q    <= '0;
        end else begin
            state_q      <= state_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            dropped_q    <= dropped_d;
        end
    end

    assign evt_valid = (state_q == ST_OFFER);
    assign evt_id    = evt_id_q;
    assign dropped   = dropped_q;

endmodule
`default_nettype wire
